// File: rtl/data_entry_ctrl.sv
// Front-panel controller: debounces four buttons, writes switch bytes into data memory,
// launches the processor and shows memory readback on the seven-segment display.
module data_entry_ctrl #(
   parameter int DB_CYCLES = 3,
   parameter int ADDR_W    = 3
) (
   input  logic        clk_100mhz,
   input  logic        i_rst_n,
   input  logic        pulse_next_sw,
   input  logic        pulse_prev_sw,
   input  logic        wen_sw,
   input  logic        start_sw,
   input  logic [7:0]  wdata_sw,
   input  logic        data_result,
   input  logic        cpu_done,
   input  logic [31:0] mem_rdata,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_start,
   output logic [15:0] disp_value,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      ENTRY  = 2'd0,
      RUN    = 2'd1,
      RESULT = 2'd2
   } state_t;

   localparam int NB = 4;
   localparam int B_NEXT  = 0;
   localparam int B_PREV  = 1;
   localparam int B_WEN   = 2;
   localparam int B_START = 3;
   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   // Reset asserts at once and releases two clocks later; the two further stages
   // mark when the input synchronizers hold real samples again.
   logic [3:0] rst_pipe;
   logic       rst_n;
   logic       settled;

   always_ff @(posedge clk_100mhz or negedge i_rst_n) begin
      if (!i_rst_n) rst_pipe <= '0;
      else          rst_pipe <= {rst_pipe[2:0], 1'b1};
   end

   assign rst_n   = rst_pipe[1];
   assign settled = rst_pipe[3];

   logic [NB-1:0] btn_raw, btn_s1, btn_s2, btn_db, btn_db_prev, btn_armed, btn_edge;
   logic [CW-1:0] db_cnt [NB];
   logic [7:0]    wd_s1, wd_s2;
   logic          dr_s1, dr_s2;

   assign btn_raw = {start_sw, wen_sw, pulse_prev_sw, pulse_next_sw};

   // A button only becomes armed once it is seen released after reset, so a
   // button held through reset cannot produce a press edge.
   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1      <= '0;
         btn_s2      <= '0;
         btn_db      <= '0;
         btn_db_prev <= '0;
         btn_armed   <= '0;
         btn_edge    <= '0;
         wd_s1       <= '0;
         wd_s2       <= '0;
         dr_s1       <= 1'b0;
         dr_s2       <= 1'b0;
         // NOTE: these counters are ordinary flops, so they are reset; a RAM-backed array would not be.
         for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample pre-edge values, whatever the statement order.
         btn_s1      <= btn_raw;
         btn_s2      <= btn_s1;
         wd_s1       <= wdata_sw;
         wd_s2       <= wd_s1;
         dr_s1       <= data_result;
         dr_s2       <= dr_s1;
         btn_db_prev <= btn_db;
         btn_edge    <= btn_db & ~btn_db_prev & btn_armed;
         for (int i = 0; i < NB; i++) begin
            if (btn_s2[i] == btn_db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               btn_db[i] <= btn_s2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
            if (settled && !btn_db[i] && !btn_s2[i]) btn_armed[i] <= 1'b1;
         end
      end
   end

   logic ev_next, ev_prev, ev_wen, ev_start;
   assign ev_next  = btn_edge[B_NEXT];
   assign ev_prev  = btn_edge[B_PREV];
   assign ev_wen   = btn_edge[B_WEN];
   assign ev_start = btn_edge[B_START];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d, wr_idx_q, wr_idx_d, idx_step;
   logic [7:0]        wr_byte_q, wr_byte_d, disp_q, disp_d;
   logic              mem_we_q, mem_we_d, pend_q, pend_d;

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ENTRY;
         idx_q     <= '0;
         wr_idx_q  <= '0;
         wr_byte_q <= '0;
         disp_q    <= '0;
         mem_we_q  <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wr_idx_q  <= wr_idx_d;
         wr_byte_q <= wr_byte_d;
         disp_q    <= disp_d;
         mem_we_q  <= mem_we_d;
         pend_q    <= pend_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d   = state_q;
      idx_d     = idx_q;
      wr_idx_d  = wr_idx_q;
      wr_byte_d = wr_byte_q;
      mem_we_d  = 1'b0;
      pend_d    = pend_q;
      idx_step  = idx_q;
      if (ev_next && !ev_prev)      idx_step = idx_q + 1'b1;
      else if (ev_prev && !ev_next) idx_step = idx_q - 1'b1;

      unique case (state_q)
         ENTRY: begin
            if (pend_q) begin
               // The write launched with the start press has just completed.
               state_d = RUN;
               pend_d  = 1'b0;
            end else begin
               idx_d = idx_step;
               if (ev_wen) begin
                  mem_we_d  = 1'b1;
                  wr_idx_d  = idx_q;
                  wr_byte_d = wd_s2;
               end
               if (ev_start) begin
                  if (ev_wen) pend_d  = 1'b1;
                  else        state_d = RUN;
               end
            end
         end
         RUN: begin
            if (cpu_done) begin
               state_d = RESULT;
               idx_d   = '0;
            end
         end
         RESULT: begin
            if (ev_start) begin
               state_d = ENTRY;
               idx_d   = '0;
            end else begin
               idx_d = idx_step;
            end
         end
         default: state_d = ENTRY;
      endcase

      disp_d = ((state_q == RESULT) || ((state_q == ENTRY) && dr_s2)) ? mem_rdata[7:0] : wd_s2;
   end

   logic rdata_unused;
   assign rdata_unused = ^mem_rdata[31:8];

   assign mem_we     = mem_we_q;
   assign mem_addr   = {{(30-ADDR_W){1'b0}}, (mem_we_q ? wr_idx_q : idx_q), 2'b00};
   assign mem_wdata  = {24'd0, wr_byte_q};
   assign cpu_start  = (state_q != ENTRY);
   assign disp_value = {{(8-ADDR_W){1'b0}}, idx_q, disp_q};
   assign state_o    = state_q;

endmodule

// File: tb/tb_data_entry_ctrl.sv
// Self-checking bench for data_entry_ctrl: directed scenarios plus randomized buttons,
// compared every cycle against a behavioural model built from the button/FSM rules.
module tb_data_entry_ctrl;

   localparam int DB   = 3;
   localparam int AW   = 3;
   localparam int NIDX = 1 << AW;
   localparam int S_ENTRY  = 0;
   localparam int S_RUN    = 1;
   localparam int S_RESULT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  btn = '0;        // 0 next, 1 prev, 2 wen, 3 start
   logic [7:0]  wdata = '0;
   logic        dres = 1'b0;
   logic        cpu_done = 1'b0;
   logic [31:0] rdata = '0;

   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_start;
   logic [15:0] disp_value;
   logic [1:0]  state_o;

   always #5 clk = ~clk;

   data_entry_ctrl #(.DB_CYCLES(DB), .ADDR_W(AW)) dut (
      .clk_100mhz    (clk),
      .i_rst_n       (rst_n),
      .pulse_next_sw (btn[0]),
      .pulse_prev_sw (btn[1]),
      .wen_sw        (btn[2]),
      .start_sw      (btn[3]),
      .wdata_sw      (wdata),
      .data_result   (dres),
      .cpu_done      (cpu_done),
      .mem_rdata     (rdata),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .cpu_start     (cpu_start),
      .disp_value    (disp_value),
      .state_o       (state_o)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit model_on = 0;
   int m_state, m_idx, m_wr_idx, m_wr_byte, m_disp;
   bit m_we, m_pend;
   bit m_lvl [4];
   bit m_rise [4];
   bit m_pulse [4];
   bit m_raw [4][DB+1];   // m_raw[b][i] = raw level sampled i+1 edges ago
   int m_wd [2];
   bit m_dr [2];

   task automatic model_init();
      for (int b = 0; b < 4; b++) begin
         m_lvl[b] = 0; m_rise[b] = 0; m_pulse[b] = 0;
         for (int i = 0; i <= DB; i++) m_raw[b][i] = btn[b];
      end
      m_wd[0] = wdata; m_wd[1] = wdata;
      m_dr[0] = dres;  m_dr[1] = dres;
      m_state = S_ENTRY; m_idx = 0; m_wr_idx = 0; m_wr_byte = 0;
      m_disp = wdata; m_we = 0; m_pend = 0;
   endtask

   task automatic model_step();
      bit p [4];
      int wd_use, old_state, step;
      bit dr_use, all_diff;
      for (int b = 0; b < 4; b++) p[b] = m_pulse[b];
      wd_use = m_wd[1];
      dr_use = m_dr[1];
      old_state = m_state;
      step = m_idx;
      if (p[0] && !p[1])      step = (m_idx + 1) % NIDX;
      else if (p[1] && !p[0]) step = (m_idx + NIDX - 1) % NIDX;
      m_we = 0;
      case (m_state)
         S_ENTRY: begin
            if (m_pend) begin
               m_state = S_RUN; m_pend = 0;
            end else begin
               if (p[2]) begin m_we = 1; m_wr_idx = m_idx; m_wr_byte = wd_use; end
               m_idx = step;
               if (p[3]) begin
                  if (p[2]) m_pend = 1;
                  else      m_state = S_RUN;
               end
            end
         end
         S_RUN: if (cpu_done) begin m_state = S_RESULT; m_idx = 0; end
         default: begin
            if (p[3]) begin m_state = S_ENTRY; m_idx = 0; end
            else m_idx = step;
         end
      endcase
      m_disp = (old_state == S_RESULT || (old_state == S_ENTRY && dr_use)) ? int'(rdata[7:0]) : wd_use;
      for (int b = 0; b < 4; b++) begin
         m_pulse[b] = m_rise[b];
         all_diff = 1;
         for (int i = 1; i <= DB; i++) if (m_raw[b][i] == m_lvl[b]) all_diff = 0;
         m_rise[b] = 0;
         if (all_diff) begin
            m_lvl[b] = !m_lvl[b];
            m_rise[b] = m_lvl[b];
         end
         for (int i = DB; i >= 1; i--) m_raw[b][i] = m_raw[b][i-1];
         m_raw[b][0] = btn[b];
      end
      m_wd[1] = m_wd[0]; m_wd[0] = wdata;
      m_dr[1] = m_dr[0]; m_dr[0] = dres;
   endtask

   always @(posedge clk) if (model_on) model_step();

   always @(negedge clk) begin
      if (model_on) begin
         check("mem_we",     mem_we,     m_we);
         check("mem_addr",   mem_addr,   (m_we ? m_wr_idx : m_idx) * 4);
         check("mem_wdata",  mem_wdata,  m_wr_byte);
         check("cpu_start",  cpu_start,  m_state != S_ENTRY);
         check("disp_value", disp_value, m_idx * 256 + m_disp);
         check("state",      state_o,    m_state);
      end
   end

   int we_cnt = 0;
   logic [31:0] last_addr = '0, last_data = '0;
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         we_cnt++;
         last_addr = mem_addr;
         last_data = mem_wdata;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int b, input int hold);
      btn[b] = 1'b1;
      tick(hold);
      btn[b] = 1'b0;
      tick(10);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base;
      #2 rst_n = 1'b0;
      #1;
      check("rst_state",     state_o,    0);
      check("rst_mem_we",    mem_we,     0);
      check("rst_cpu_start", cpu_start,  0);
      check("rst_disp",      disp_value, 0);
      check("rst_addr",      mem_addr,   0);
      tick(3);
      rst_n = 1'b1;
      wdata = 8'd56;
      tick(12);
      model_init();
      model_on = 1;

      // single write: latency and one-cycle strobe
      base = we_cnt;
      btn[2] = 1'b1;
      tick(6);
      check("wen_early",  mem_we, 0);
      tick(1);
      check("wen_pulse",  mem_we, 1);
      check("wen_addr",   mem_addr, 0);
      check("wen_data",   mem_wdata, 56);
      tick(1);
      check("wen_single", mem_we, 0);
      tick(2);
      btn[2] = 1'b0;
      tick(10);
      check("wen_count", we_cnt - base, 1);

      // index stepping, write at index 1, wrap both ways
      press(0, 20);
      check("idx_after_next", disp_value[15:8], 1);
      wdata = 8'd10;
      tick(4);
      base = we_cnt;
      press(2, 10);
      check("wr1_count", we_cnt - base, 1);
      check("wr1_addr",  last_addr, 4);
      check("wr1_data",  last_data, 10);
      for (int k = 0; k < 6; k++) press(0, 6);
      check("idx_max", disp_value[15:8], 7);
      press(0, 6);
      check("idx_wrap_up", disp_value[15:8], 0);
      press(1, 6);
      check("idx_wrap_down", disp_value[15:8], 7);

      // glitch and simultaneous next+prev
      base = we_cnt;
      btn[2] = 1'b1; tick(2); btn[2] = 1'b0; tick(10);
      check("glitch_no_we", we_cnt - base, 0);
      btn[0] = 1'b1; btn[1] = 1'b1; tick(10);
      btn[0] = 1'b0; btn[1] = 1'b0; tick(10);
      check("next_prev_hold", disp_value[15:8], 7);

      // RUN ignores buttons, cpu_done moves to RESULT
      press(3, 6);
      check("run_state",     state_o,   1);
      check("run_cpu_start", cpu_start, 1);
      base = we_cnt;
      press(0, 6);
      press(2, 6);
      check("run_no_we",   we_cnt - base, 0);
      check("run_idx_hold", disp_value[15:8], 7);
      cpu_done = 1'b1; tick(1); cpu_done = 1'b0;
      check("result_state", state_o, 2);
      check("result_idx",   disp_value[15:8], 0);
      rdata = 32'h0000_004E;
      tick(1);
      check("result_disp", disp_value, 16'h004E);

      // RESULT -> ENTRY
      press(0, 6);
      check("result_next", disp_value[15:8], 1);
      press(3, 6);
      check("back_state",     state_o,   0);
      check("back_cpu_start", cpu_start, 0);
      check("back_idx",       disp_value[15:8], 0);

      // reset mid-RUN with wen held mid-debounce
      rdata = '0;
      wdata = 8'h33;
      press(0, 6);
      press(3, 6);
      check("pre_rst_cpu_start", cpu_start, 1);
      check("pre_rst_disp",      disp_value, 16'h0133);
      btn[2] = 1'b1;
      tick(3);
      model_on = 0;
      #2 rst_n = 1'b0;
      #1;
      check("rst2_mem_we",    mem_we,     0);
      check("rst2_addr",      mem_addr,   0);
      check("rst2_wdata",     mem_wdata,  0);
      check("rst2_cpu_start", cpu_start,  0);
      check("rst2_disp",      disp_value, 0);
      check("rst2_state",     state_o,    0);
      @(negedge clk);
      rst_n = 1'b1;
      base = we_cnt;
      tick(30);
      check("held_no_we",    we_cnt - base, 0);
      check("held_state",    state_o, 0);
      btn[2] = 1'b0;
      tick(15);
      model_init();
      model_on = 1;

      // randomized phase
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) btn[b] = ~btn[b];
         cpu_done = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 15) == 0) wdata = 8'($urandom);
         if ($urandom_range(0, 31) == 0) dres = ~dres;
         rdata = $urandom;
      end
      btn = '0;
      cpu_done = 1'b0;
      tick(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/data_entry_ctrl.md
DATA_ENTRY_CTRL -- requirements
Module: data_entry_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 3: consecutive stable synchronized samples required before a debounced button changes.
REQ-002 SHALL have parameter ADDR_W, default 3: entry-index width, giving 2**ADDR_W data-memory slots.
REQ-003 SHALL have port clk_100mhz  in  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have port i_rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port pulse_next_sw  in  1  raw button, increment entry index.
REQ-006 SHALL have port pulse_prev_sw  in  1  raw button, decrement entry index.
REQ-007 SHALL have port wen_sw  in  1  raw button, write the switch byte to the current entry.
REQ-008 SHALL have port start_sw  in  1  raw button, launch the processor.
REQ-009 SHALL have port wdata_sw  in  8  switch byte, sampled through a 2-FF synchronizer with no debounce.
REQ-010 SHALL have port data_result  in  1  level, 2-FF synchronized; high in ENTRY shows memory readback instead of switches.
REQ-011 SHALL have port cpu_done  in  1  end-of-program pulse from processor writeback.
REQ-012 SHALL have port mem_rdata  in  32  data-memory read word, valid one cycle after mem_addr.
REQ-013 SHALL have port mem_we  out  1  one-cycle data-memory write strobe.
REQ-014 SHALL have port mem_addr  out  32  byte address = index*4, upper bits zero.
REQ-015 SHALL have port mem_wdata  out  32  {24'd0, byte}.
REQ-016 SHALL have port cpu_start  out  1  processor run enable.
REQ-017 SHALL have port disp_value  out  16  {index zero-extended to 8 bits, display byte}, for the seven-segment driver.
REQ-018 SHALL have port state_o  out  2  current state encoding: ENTRY=0, RUN=1, RESULT=2.

Function
REQ-019 Each raw button SHALL pass a 2-FF synchronizer, then a debouncer whose output toggles only after DB_CYCLES consecutive samples differ from it; the counter clears on any matching sample.
REQ-020 A one-cycle edge pulse SHALL fire on each debounced 0->1 transition only, exactly 2+DB_CYCLES cycles after raw is first sampled high, and never repeat while held.
REQ-021 Glitches shorter than DB_CYCLES synchronized cycles SHALL produce no edge.
REQ-022 In ENTRY and RESULT, a next edge SHALL increment index mod 2**ADDR_W, so max wraps to 0.
REQ-023 In ENTRY and RESULT, a prev edge SHALL decrement index mod 2**ADDR_W, so 0 wraps to max.
REQ-024 Next and prev edges in the same cycle SHALL leave index unchanged.
REQ-025 In ENTRY, a wen edge SHALL assert mem_we for exactly one cycle on the next clock, with mem_addr and mem_wdata taken from the pre-update index and synchronized byte.
REQ-026 A wen edge coinciding with a next or prev edge SHALL write the old index; index updates on the same edge.
REQ-027 mem_addr SHALL always equal current index*4, except during the mem_we cycle of REQ-025.
REQ-028 The display byte register SHALL load mem_rdata[7:0] every cycle in RESULT, and in ENTRY when data_result is high; otherwise it loads the synchronized wdata_sw.
REQ-029 Transitions: ENTRY --start edge--> RUN. RUN --cpu_done--> RESULT. RESULT --start edge--> ENTRY.
REQ-030 A start edge coinciding with a wen edge in ENTRY SHALL complete the write, and the write cycle SHALL occur before RUN.
REQ-031 cpu_start SHALL be 1 exactly in RUN and RESULT, asserted the cycle after the start edge.
REQ-032 In RUN, all button edges except the terminating cpu_done SHALL be ignored; mem_we SHALL stay 0 and the index SHALL hold.
REQ-033 On entering RESULT and on entering ENTRY, index SHALL clear to 0.
REQ-034 cpu_done outside RUN SHALL be ignored.
REQ-035 wen edges in RESULT SHALL be ignored.

Reset
REQ-036 i_rst_n low SHALL immediately clear: state to ENTRY, index, mem_we, cpu_start, display byte, synchronizers, debounce counters and debounced levels.
REQ-037 Assertion mid-write or mid-RUN SHALL abort with no further mem_we pulse.
REQ-038 Deassertion SHALL be synchronized internally so that no edge fires for buttons held through reset until they are released and pressed again.

Verification
REQ-039 wdata_sw=56, wen_sw held 10 cycles -> one mem_we pulse, mem_addr=0, mem_wdata=56, 2+3+1 cycles after the press.
REQ-040 next held 20 cycles, wdata_sw=10, wen -> write addr 4 data 10; 7 more next presses -> index wraps 7->0; prev at 0 -> index 7, disp_value[15:8]=7.
REQ-041 2-cycle wen glitch and simultaneous next+prev -> no mem_we, index unchanged.
REQ-042 start press -> state 1, cpu_start=1; next/wen during RUN -> ignored; cpu_done pulse -> state 2, index 0; mem_rdata=0x0000004E -> disp_value=0x004E next cycle.
REQ-043 Reset asserted with wen held mid-debounce -> all outputs 0 immediately; after release with wen still held, no mem_we.
REQ-044 In RESULT, a start press -> state 0, cpu_start=0, index 0.
